mouse_master_sequencer: RTL and testbench

- Controls the PS/2 mouse transmitter and receiver inside the mouse transceiver.
- Initialisation:
  - sends Reset (0xFF);
  - checks ACK (0xFA), self-test pass (0xAA) and device ID (0x00);
  - sends Enable Data Reporting (0xF4) and checks its ACK.
- Streaming: assembles 3-byte movement packets and presents status/DX/DY with a one-cycle interrupt to the position tracker.
- Adds per-state watchdog timeouts, bounded init retries and packet resynchronisation.

---
 rtl/mouse_master_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_mouse_master_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_master_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_master_sequencer
//  Purpose  : Master controller for a PS/2 mouse transceiver. It resets the
//             mouse and checks its replies (ACK, self-test pass, device ID).
//             It then enables data reporting. After that it collects 3-byte
//             movement packets and publishes them with a one-cycle interrupt.
//             Each wait state has a watchdog. Init is retried a bounded
//             number of times. Packets resynchronise on the status byte.
//  Ports    : CLK, RESET          - clock, synchronous active-high reset
//             SEND_BYTE, BYTE_TO_SEND, BYTE_SENT  - transmitter handshake
//             READ_ENABLE, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
//                                 - receiver handshake
//             MOUSE_STATUS/DX/DY, SEND_INTERRUPT  - published packet
//             INIT_DONE, INIT_FAIL                - initialisation status
//  Revision : 1.0 - initial release
// ============================================================================
module mouse_master_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic       INIT_FAIL
);

  typedef enum logic [3:0] {
    S_START, S_TX_RST, S_WT_RST_SENT, S_WT_ACK1, S_WT_BAT, S_WT_ID,
    S_TX_EN, S_WT_EN_SENT, S_WT_ACK2, S_RD_B0, S_RD_B1, S_RD_B2,
    S_PUB, S_FAIL
  } state_t;

  localparam logic [31:0] c_WdogLimit  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  c_MaxRetries = 4'(MAX_RETRIES);

  state_t      r_state, w_nextState;
  logic [31:0] r_wdog;
  logic [3:0]  r_retry;
  logic [3:0]  w_retryNext;
  logic [7:0]  r_byteToSend;
  logic [7:0]  r_b0, r_b1;
  logic [7:0]  r_status, r_dx, r_dy;
  logic        r_initDone;

  logic        w_isWait, w_timeout, w_rxErr;
  logic        w_initWait, w_initFailEvt;
  logic [7:0]  w_expect;
  state_t      w_goodNext;

  // S_RD_B0 has no watchdog: the mouse can be idle indefinitely between packets.
  assign w_isWait = (r_state == S_WT_RST_SENT) || (r_state == S_WT_ACK1) ||
                    (r_state == S_WT_BAT)      || (r_state == S_WT_ID)   ||
                    (r_state == S_WT_EN_SENT)  || (r_state == S_WT_ACK2) ||
                    (r_state == S_RD_B1)       || (r_state == S_RD_B2);
  assign w_timeout   = w_isWait && (r_wdog == c_WdogLimit);
  assign w_rxErr     = (BYTE_ERROR_CODE != 2'b00);
  assign w_retryNext = r_retry + 4'd1;

  always_comb begin
    w_nextState   = r_state;
    w_initWait    = 1'b0;
    w_initFailEvt = 1'b0;
    w_expect      = 8'h00;
    w_goodNext    = r_state;
    case (r_state)
      S_START:       w_nextState = S_TX_RST;
      S_TX_RST:      w_nextState = S_WT_RST_SENT;
      S_TX_EN:       w_nextState = S_WT_EN_SENT;
      // BYTE_SENT is only honoured here, never during the SEND_BYTE cycle.
      S_WT_RST_SENT: begin
        if (BYTE_SENT)      w_nextState   = S_WT_ACK1;
        else if (w_timeout) w_initFailEvt = 1'b1;
      end
      S_WT_EN_SENT: begin
        if (BYTE_SENT)      w_nextState   = S_WT_ACK2;
        else if (w_timeout) w_initFailEvt = 1'b1;
      end
      S_WT_ACK1: begin w_initWait = 1'b1; w_expect = 8'hFA; w_goodNext = S_WT_BAT; end
      S_WT_BAT:  begin w_initWait = 1'b1; w_expect = 8'hAA; w_goodNext = S_WT_ID;  end
      S_WT_ID:   begin w_initWait = 1'b1; w_expect = 8'h00; w_goodNext = S_TX_EN;  end
      S_WT_ACK2: begin w_initWait = 1'b1; w_expect = 8'hFA; w_goodNext = S_RD_B0;  end
      // Only a byte with bit 3 set can be a status byte; anything else is dropped.
      S_RD_B0: begin
        if (BYTE_READY && !w_rxErr && BYTE_READ[3]) w_nextState = S_RD_B1;
      end
      S_RD_B1: begin
        if (BYTE_READY)     w_nextState = w_rxErr ? S_RD_B0 : S_RD_B2;
        else if (w_timeout) w_nextState = S_RD_B0;
      end
      S_RD_B2: begin
        if (BYTE_READY)     w_nextState = w_rxErr ? S_RD_B0 : S_PUB;
        else if (w_timeout) w_nextState = S_RD_B0;
      end
      S_PUB:   w_nextState = S_RD_B0;
      S_FAIL:  w_nextState = S_FAIL;
      default: w_nextState = S_START;
    endcase

    // A received byte takes priority over a watchdog expiry in the same cycle.
    if (w_initWait) begin
      if (BYTE_READY) begin
        if (w_rxErr || (BYTE_READ != w_expect)) w_initFailEvt = 1'b1;
        else                                    w_nextState   = w_goodNext;
      end else if (w_timeout) begin
        w_initFailEvt = 1'b1;
      end
    end

    if (w_initFailEvt)
      w_nextState = (w_retryNext == c_MaxRetries) ? S_FAIL : S_TX_RST;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_START;
      r_wdog       <= 32'd0;
      r_retry      <= 4'd0;
      r_byteToSend <= 8'h00;
      r_b0         <= 8'h00;
      r_b1         <= 8'h00;
      r_status     <= 8'h00;
      r_dx         <= 8'h00;
      r_dy         <= 8'h00;
      r_initDone   <= 1'b0;
    end else begin
      r_state <= w_nextState;

      if ((w_nextState != r_state) || !w_isWait) r_wdog <= 32'd0;
      else                                      r_wdog <= r_wdog + 32'd1;

      if (w_initFailEvt)              r_retry <= w_retryNext;
      else if (w_nextState == S_RD_B0) r_retry <= 4'd0;

      // The command byte is loaded on entry to the TX state and held until
      // the next command, so it stays stable through the BYTE_SENT wait.
      if (w_nextState == S_TX_RST)     r_byteToSend <= 8'hFF;
      else if (w_nextState == S_TX_EN) r_byteToSend <= 8'hF4;

      if ((r_state == S_RD_B0) && (w_nextState == S_RD_B1)) r_b0 <= BYTE_READ;
      if ((r_state == S_RD_B1) && (w_nextState == S_RD_B2)) r_b1 <= BYTE_READ;

      // Load on entry to S_PUB so the outputs are already valid when the
      // interrupt is raised.
      if ((r_state == S_RD_B2) && (w_nextState == S_PUB)) begin
        r_status <= r_b0;
        r_dx     <= r_b1;
        r_dy     <= BYTE_READ;
      end

      if ((r_state == S_WT_ACK2) && (w_nextState == S_RD_B0)) r_initDone <= 1'b1;
    end
  end

  assign SEND_BYTE      = (r_state == S_TX_RST) || (r_state == S_TX_EN);
  assign BYTE_TO_SEND   = r_byteToSend;
  assign READ_ENABLE    = (r_state == S_WT_ACK1) || (r_state == S_WT_BAT) ||
                          (r_state == S_WT_ID)   || (r_state == S_WT_ACK2) ||
                          (r_state == S_RD_B0)   || (r_state == S_RD_B1) ||
                          (r_state == S_RD_B2);
  assign SEND_INTERRUPT = (r_state == S_PUB);
  assign MOUSE_STATUS   = r_status;
  assign MOUSE_DX       = r_dx;
  assign MOUSE_DY       = r_dy;
  assign INIT_DONE      = r_initDone;
  assign INIT_FAIL      = (r_state == S_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_mouse_master_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mouse_master_sequencer
//  Purpose  : Directed self-checking bench for mouse_master_sequencer.
//             It covers init, packets, resync, stream errors and timeouts,
//             mid-stream reset, init retry and init failure.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mouse_master_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BYTE_READY = 1'b0;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic       SEND_INTERRUPT, INIT_DONE, INIT_FAIL;

  int vectors     = 0;
  int miscompares = 0;
  int sendCount   = 0;
  int sendBase    = 0;

  mouse_master_sequencer #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .SEND_INTERRUPT(SEND_INTERRUPT), .INIT_DONE(INIT_DONE), .INIT_FAIL(INIT_FAIL)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (SEND_BYTE === 1'b1) sendCount++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] err);
    BYTE_READ = b;
    BYTE_ERROR_CODE = err;
    BYTE_READY = 1'b1;
    tick();
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  // Wait (bounded) for a command request, check it, then acknowledge it.
  // With early=1, BYTE_SENT is also driven in the SEND_BYTE cycle. That
  // pulse must be ignored.
  task automatic txAck(input string tag, input logic [7:0] exp, input bit early);
    int n = 0;
    while (SEND_BYTE !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 8'(SEND_BYTE), 8'd1);
    chk({tag, "_byte"}, BYTE_TO_SEND, exp);
    BYTE_SENT = early;
    tick();
    BYTE_SENT = 1'b0;
    if (early) begin
      chk({tag, "_earlyIgnored"}, 8'(READ_ENABLE), 8'd0);
      chk({tag, "_held"}, BYTE_TO_SEND, exp);
    end
    tick();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_send",   8'(SEND_BYTE), 8'd0);
    chk("rst_byte",   BYTE_TO_SEND, 8'h00);
    chk("rst_rden",   8'(READ_ENABLE), 8'd0);
    chk("rst_irq",    8'(SEND_INTERRUPT), 8'd0);
    chk("rst_done",   8'(INIT_DONE), 8'd0);
    chk("rst_fail",   8'(INIT_FAIL), 8'd0);
    chk("rst_status", MOUSE_STATUS, 8'h00);
    chk("rst_dx",     MOUSE_DX, 8'h00);
    chk("rst_dy",     MOUSE_DY, 8'h00);

    // ---------------- nominal init ----------------
    sendBase = sendCount;
    RESET = 1'b0;
    tick();
    txAck("init_rst", 8'hFF, 1'b0);
    chk("init_rden_ack1", 8'(READ_ENABLE), 8'd1);
    rx(8'hFA, 2'b00);
    rx(8'hAA, 2'b00);
    rx(8'h00, 2'b00);
    txAck("init_en", 8'hF4, 1'b1);
    chk("init_done_before_ack2", 8'(INIT_DONE), 8'd0);
    rx(8'hFA, 2'b00);
    chk("init_done",  8'(INIT_DONE), 8'd1);
    chk("init_rden",  8'(READ_ENABLE), 8'd1);
    chk("init_sends", 8'(sendCount - sendBase), 8'd2);

    // ---------------- packet ----------------
    rx(8'h28, 2'b00);
    chk("pkt_noirq_b1", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'h05, 2'b00);
    chk("pkt_noirq_b2", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'hFB, 2'b00);
    chk("pkt_irq",    8'(SEND_INTERRUPT), 8'd1);
    chk("pkt_status", MOUSE_STATUS, 8'h28);
    chk("pkt_dx",     MOUSE_DX, 8'h05);
    chk("pkt_dy",     MOUSE_DY, 8'hFB);
    chk("pkt_rden_pub", 8'(READ_ENABLE), 8'd0);
    // A byte offered during S_PUB must be dropped.
    rx(8'h18, 2'b00);
    chk("pkt_irq_once", 8'(SEND_INTERRUPT), 8'd0);
    chk("pkt_hold_status", MOUSE_STATUS, 8'h28);
    chk("pkt_hold_dy",     MOUSE_DY, 8'hFB);

    // ---------------- resync ----------------
    rx(8'h05, 2'b00);
    chk("sync_noirq_a", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'h08, 2'b00);
    chk("sync_noirq_b", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'h01, 2'b00);
    chk("sync_noirq_c", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'h02, 2'b00);
    chk("sync_irq",    8'(SEND_INTERRUPT), 8'd1);
    chk("sync_status", MOUSE_STATUS, 8'h08);
    chk("sync_dx",     MOUSE_DX, 8'h01);
    chk("sync_dy",     MOUSE_DY, 8'h02);
    tick();

    // ---------------- stream error ----------------
    rx(8'h08, 2'b00);
    rx(8'h33, 2'b01);
    chk("serr_noirq_a", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'h09, 2'b00);
    chk("serr_noirq_b", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'h10, 2'b00);
    chk("serr_noirq_c", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'h20, 2'b00);
    chk("serr_irq",    8'(SEND_INTERRUPT), 8'd1);
    chk("serr_status", MOUSE_STATUS, 8'h09);
    chk("serr_dx",     MOUSE_DX, 8'h10);
    chk("serr_dy",     MOUSE_DY, 8'h20);
    tick();

    // ---------------- stream timeout ----------------
    rx(8'h08, 2'b00);
    repeat (16) tick();
    rx(8'h0A, 2'b00);
    chk("sto_noirq_a", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'h0B, 2'b00);
    chk("sto_noirq_b", 8'(SEND_INTERRUPT), 8'd0);
    rx(8'h0C, 2'b00);
    chk("sto_irq",    8'(SEND_INTERRUPT), 8'd1);
    chk("sto_status", MOUSE_STATUS, 8'h0A);
    chk("sto_dy",     MOUSE_DY, 8'h0C);
    chk("sto_done",   8'(INIT_DONE), 8'd1);

    // ---------------- mid-stream reset, init error then retry ----------------
    rx(8'h08, 2'b00);
    RESET = 1'b1;
    tick();
    chk("mrst_done",   8'(INIT_DONE), 8'd0);
    chk("mrst_status", MOUSE_STATUS, 8'h00);
    chk("mrst_rden",   8'(READ_ENABLE), 8'd0);
    sendBase = sendCount;
    RESET = 1'b0;
    tick();
    txAck("ierr_rst1", 8'hFF, 1'b0);
    rx(8'hFE, 2'b00);
    chk("ierr_retry_req", 8'(SEND_BYTE), 8'd1);
    txAck("ierr_rst2", 8'hFF, 1'b0);
    rx(8'hFA, 2'b00);
    rx(8'hAA, 2'b00);
    rx(8'h00, 2'b00);
    txAck("ierr_en", 8'hF4, 1'b0);
    rx(8'hFA, 2'b00);
    chk("ierr_done",  8'(INIT_DONE), 8'd1);
    chk("ierr_sends", 8'(sendCount - sendBase), 8'd3);

    // ---------------- retry exhaustion ----------------
    RESET = 1'b1;
    tick();
    sendBase = sendCount;
    RESET = 1'b0;
    tick();
    txAck("fail_rst1", 8'hFF, 1'b0);
    txAck("fail_rst2", 8'hFF, 1'b0);
    txAck("fail_rst3", 8'hFF, 1'b0);
    begin
      int n = 0;
      while (INIT_FAIL !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
    end
    chk("fail_flag", 8'(INIT_FAIL), 8'd1);
    chk("fail_done", 8'(INIT_DONE), 8'd0);
    repeat (30) tick();
    chk("fail_sends",  8'(sendCount - sendBase), 8'd3);
    chk("fail_sticky", 8'(INIT_FAIL), 8'd1);
    RESET = 1'b1;
    tick();
    chk("fail_rst_clear", 8'(INIT_FAIL), 8'd0);
    RESET = 1'b0;
    tick();
    chk("fail_restart_req",  8'(SEND_BYTE), 8'd1);
    chk("fail_restart_byte", BYTE_TO_SEND, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
